clause_array_bcp: RTL and testbench
===================================

Name: clause_array_bcp

Overview:
- Parametrised successor to the two-clause array.
- Holds NUM_CLAUSES clauses over NUM_VARS local variables and supports one-hot load/readback.
- On request, runs iterative Boolean constraint propagation (unit implication to a fixed point) over the stored clauses.
- Returns the final assignment, the conflict status and the all-satisfied status with a start/done handshake. It sits inside the sat_engine between the variable-state block and the engine controller.

Parameters:
NUM_CLAUSES, 8, number of clause slots (>=1)
NUM_VARS, 8, variables per clause/assignment
WIDTH_C_LEN, 4, clause length field width
MAX_ITER, 8, propagation pass limit (>=1)
WIDTH_IDX, 3, width of clause index, >= clog2(NUM_CLAUSES), min 1

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
var_value_i  in  NUM_VARS*3  assignment snapshot, sampled on accepted start
var_value_o  out  NUM_VARS*3  working/final assignment (registered)
wr_i  in  NUM_CLAUSES  one-hot clause write select
rd_i  in  NUM_CLAUSES  one-hot clause read select
clause_i  in  NUM_VARS*2  clause literals to write
clause_o  out  NUM_VARS*2  read-back literals (registered)
clause_len_i  in  WIDTH_C_LEN  length to write
clause_len_o  out  WIDTH_C_LEN*NUM_CLAUSES  all stored lengths, slot k at [k*W+:W]
clear_i  in  1  invalidate all clauses
start_i  in  1  start propagation
busy_o  out  1  propagation in progress
done_o  out  1  one-cycle completion pulse
conflict_o  out  1  last run ended in conflict
conflict_idx_o  out  WIDTH_IDX  clause index of conflict
timeout_o  out  1  last run hit MAX_ITER
all_c_sat_o  out  1  every valid clause satisfied by var_value_o

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Variable encoding: var i at [3i+2:3i] = {imp, val[1:0]}.
  - val: 01 = true, 10 = false, 00 = free, 11 = treated as free.
  - imp = 1 marks a variable implied by this block.
- Literal encoding: lit i at [2i+1:2i]: 01 = positive, 10 = negative, 00/11 = absent.
- Clause validity: a clause is valid iff its stored length is not 0.
- Per-clause evaluation against working assignment W:
  - sat: any literal true.
  - falsified: valid, not sat, no free literal.
  - unit: valid, not sat, exactly one free literal. A unit clause implies that variable to the value making its literal true, with imp = 1.
- Collision: two unit clauses imply opposite values for the same variable in one pass.
- Storage:
  - wr_i[k]=1 while IDLE writes clause_i and clause_len_i into slot k next edge. Multiple bits set write all selected slots.
  - wr_i is ignored while busy_o=1.
  - clear_i zeroes all lengths and literals next edge. It is ignored while busy.
  - clear_i has priority over wr_i.
- Readback:
  - clause_o is the OR of all rd_i-selected slots, registered, 1-cycle latency. Zero if none selected.
  - Readback is allowed in any state.
  - clause_len_o is a direct view of the storage registers.
- FSM IDLE -> EVAL -> IDLE.
  - IDLE: start_i=1 loads W <= var_value_i, clears conflict_o/timeout_o, pass counter <= 0, busy_o <= 1.
  - EVAL (one pass per cycle): evaluate all clauses on W.
    - Any falsified clause or collision: conflict_o <= 1, W unchanged, finish.
    - No new implications: finish.
    - Otherwise: W <= W with implications merged. If pass counter == MAX_ITER-1, set timeout_o <= 1 and finish (implications of this pass are kept); else increment the counter.
  - finish: done_o pulses 1 cycle, busy_o <= 0, return to IDLE.
  - start_i while busy is ignored.
- conflict_idx_o:
  - The lowest-index falsified clause.
  - If there is no falsified clause, the lowest-index unit clause involved in a collision.
  - Holds until the next accepted start.
- var_value_o = W (registered). It is updated each pass and holds after done.
- all_c_sat_o is registered from W and valid from done onward. It is 1 when there are no valid clauses.
- Latency: a run of n implication passes completes with done_o n+1 cycles after the start edge. Minimum is 1 cycle.
- Reset values:
  - All clause storage and W = 0.
  - clause_o, busy_o, done_o, conflict_o, conflict_idx_o, timeout_o = 0.
  - all_c_sat_o = 1.
  - FSM = IDLE.
  - Reset mid-EVAL aborts with no done pulse.

Optional Feature:
- CLAUSE_ARRAY_BCP_STATS_EN defined: adds output pass_cnt_o [15:0], the total EVAL cycles since reset. It saturates at 16'hFFFF and is cleared by rst only.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Load/readback (NUM_VARS=8):
  - wr_i=8'h01, clause_i=16'h0005, len=2 -> next cycle rd_i=8'h01 -> clause_o=16'h0005 one cycle later, clause_len_o[3:0]=2.
  - clear_i -> clause_len_o=0.
- Single implication: C0=16'h0005 len 2, var_value_i=24'h000002, start -> done_o 2 cycles after start, var_value_o=24'h00002A, conflict_o=0, all_c_sat_o=1.
- Chain: C0=16'h0006, C1=16'h0018 (len 2 each), var_value_i=24'h000001 -> done_o 3 cycles after start, var_value_o=24'h000169, timeout_o=0.
- Collision: C0=16'h0001 len 1, C1=16'h0002 len 1, var_value_i=0 -> done_o after 1 cycle, conflict_o=1, conflict_idx_o=0, var_value_o=0.
- Timeout: chain test with MAX_ITER=1 -> done_o after 1 cycle, timeout_o=1, var_value_o=24'h000029.
- Reset mid-EVAL during the chain run -> busy_o=0 and no done_o; rd_i=8'h01 returns clause_o=0; the next start with no clauses -> all_c_sat_o=1.

Source files
------------

// File: rtl/clause_array_bcp.sv
// Clause store with one-hot load/readback and iterative unit propagation; done_o arrives n+1 cycles after start for n implication passes.
// Defining CLAUSE_ARRAY_BCP_STATS_EN adds pass_cnt_o, a saturating count of EVAL cycles since reset.
module clause_array_bcp #(
  parameter int NUM_CLAUSES = 8,
  parameter int NUM_VARS    = 8,
  parameter int WIDTH_C_LEN = 4,
  parameter int MAX_ITER    = 8,
  parameter int WIDTH_IDX   = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_VARS*3-1:0]              var_value_i,
  output logic [NUM_VARS*3-1:0]              var_value_o,
  input  logic [NUM_CLAUSES-1:0]             wr_i,
  input  logic [NUM_CLAUSES-1:0]             rd_i,
  input  logic [NUM_VARS*2-1:0]              clause_i,
  output logic [NUM_VARS*2-1:0]              clause_o,
  input  logic [WIDTH_C_LEN-1:0]             clause_len_i,
  output logic [WIDTH_C_LEN*NUM_CLAUSES-1:0] clause_len_o,
  input  logic                               clear_i,
  input  logic                               start_i,
  output logic                               busy_o,
  output logic                               done_o,
  output logic                               conflict_o,
  output logic [WIDTH_IDX-1:0]               conflict_idx_o,
  output logic                               timeout_o,
  output logic                               all_c_sat_o
`ifdef CLAUSE_ARRAY_BCP_STATS_EN
  ,
  output logic [15:0]                        pass_cnt_o
`endif
);

  localparam int WIDTH_PC = (MAX_ITER > 1) ? $clog2(MAX_ITER) : 1;

  typedef enum logic {ST_IDLE, ST_EVAL} state_t;

  state_t                  state_q;
  logic [NUM_VARS*2-1:0]   lits_q [NUM_CLAUSES];
  logic [WIDTH_C_LEN-1:0]  len_q  [NUM_CLAUSES];
  logic [NUM_VARS*2-1:0]   clause_q, clause_d;
  logic [NUM_VARS*3-1:0]   w_q, w_d;
  logic                    busy_q, done_q, conflict_q, timeout_q, all_sat_q, all_sat_d;
  logic [WIDTH_IDX-1:0]    conf_idx_q, conf_idx_d, idx_f, idx_c;
  logic [WIDTH_PC-1:0]     pass_q;

  logic [NUM_VARS-1:0]     v_true, v_false, v_free;
  logic [NUM_VARS-1:0]     imp_pos, imp_neg, coll_v;
  logic [NUM_VARS-1:0]     imp_pos_c [NUM_CLAUSES];
  logic [NUM_VARS-1:0]     imp_neg_c [NUM_CLAUSES];
  logic [NUM_CLAUSES-1:0]  valid, sat, sat_m, fals, unit, coll_unit;
  logic                    conflict_now, new_imp, merge;

  // Clause storage: writes and clear only while idle, clear wins over writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_CLAUSES; k++) begin
        lits_q[k] <= '0;
        len_q[k]  <= '0;
      end
    end else if (!busy_q) begin
      for (int k = 0; k < NUM_CLAUSES; k++) begin
        if (clear_i) begin
          lits_q[k] <= '0;
          len_q[k]  <= '0;
        end else if (wr_i[k]) begin
          lits_q[k] <= clause_i;
          len_q[k]  <= clause_len_i;
        end
      end
    end
  end

  always_comb begin
    clause_d = '0;
    for (int k = 0; k < NUM_CLAUSES; k++) begin
      if (rd_i[k]) clause_d = clause_d | lits_q[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) clause_q <= '0;
    else     clause_q <= clause_d;
  end

  always_comb begin
    for (int j = 0; j < NUM_VARS; j++) begin
      v_true[j]  = (w_q[3*j +: 2] == 2'b01);
      v_false[j] = (w_q[3*j +: 2] == 2'b10);
    end
    v_free = ~(v_true | v_false);
  end

  for (genvar c = 0; c < NUM_CLAUSES; c++) begin : g_cl
    logic [NUM_VARS-1:0] lpos, lneg, free;
    always_comb begin
      for (int j = 0; j < NUM_VARS; j++) begin
        lpos[j] = (lits_q[c][2*j +: 2] == 2'b01);
        lneg[j] = (lits_q[c][2*j +: 2] == 2'b10);
      end
    end
    assign free         = (lpos | lneg) & v_free;
    assign valid[c]     = |len_q[c];
    assign sat[c]       = |((lpos & v_true) | (lneg & v_false));
    assign fals[c]      = valid[c] & ~sat[c] & ~(|free);
    assign unit[c]      = valid[c] & ~sat[c] & $onehot(free);
    assign imp_pos_c[c] = unit[c] ? (lpos & free) : '0;
    assign imp_neg_c[c] = unit[c] ? (lneg & free) : '0;
    // Satisfaction as it will be once this pass's implications are merged.
    assign sat_m[c]     = sat[c] | |((lpos & imp_pos) | (lneg & imp_neg));
    assign coll_unit[c] = unit[c] & |(free & coll_v);
  end

  always_comb begin
    imp_pos = '0;
    imp_neg = '0;
    for (int c = 0; c < NUM_CLAUSES; c++) begin
      imp_pos = imp_pos | imp_pos_c[c];
      imp_neg = imp_neg | imp_neg_c[c];
    end
  end

  assign coll_v       = imp_pos & imp_neg;
  assign conflict_now = (|fals) | (|coll_v);
  assign new_imp      = |(imp_pos | imp_neg);
  assign merge        = (state_q == ST_EVAL) & ~conflict_now & new_imp;
  assign all_sat_d    = &(~valid | (merge ? sat_m : sat));

  always_comb begin
    idx_f = '0;
    idx_c = '0;
    for (int c = NUM_CLAUSES-1; c >= 0; c--) begin
      if (fals[c])      idx_f = WIDTH_IDX'(c);
      if (coll_unit[c]) idx_c = WIDTH_IDX'(c);
    end
    conf_idx_d = (|fals) ? idx_f : idx_c;
  end

  always_comb begin
    w_d = w_q;
    for (int j = 0; j < NUM_VARS; j++) begin
      if (imp_pos[j])      w_d[3*j +: 3] = 3'b101;
      else if (imp_neg[j]) w_d[3*j +: 3] = 3'b110;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      w_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      conflict_q <= 1'b0;
      conf_idx_q <= '0;
      timeout_q  <= 1'b0;
      all_sat_q  <= 1'b1;
      pass_q     <= '0;
    end else begin
      done_q    <= 1'b0;
      all_sat_q <= all_sat_d;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            w_q        <= var_value_i;
            conflict_q <= 1'b0;
            conf_idx_q <= '0;
            timeout_q  <= 1'b0;
            pass_q     <= '0;
            busy_q     <= 1'b1;
            state_q    <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          if (conflict_now) begin
            conflict_q <= 1'b1;
            conf_idx_q <= conf_idx_d;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= ST_IDLE;
          end else if (!new_imp) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            w_q <= w_d;
            if (pass_q == WIDTH_PC'(MAX_ITER-1)) begin
              timeout_q <= 1'b1;
              done_q    <= 1'b1;
              busy_q    <= 1'b0;
              state_q   <= ST_IDLE;
            end else begin
              pass_q <= pass_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef CLAUSE_ARRAY_BCP_STATS_EN
  logic [15:0] pass_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) pass_cnt_q <= '0;
    else if (state_q == ST_EVAL && pass_cnt_q != 16'hFFFF) pass_cnt_q <= pass_cnt_q + 16'd1;
  end
  assign pass_cnt_o = pass_cnt_q;
`endif

  for (genvar k = 0; k < NUM_CLAUSES; k++) begin : g_len
    assign clause_len_o[k*WIDTH_C_LEN +: WIDTH_C_LEN] = len_q[k];
  end

  assign var_value_o    = w_q;
  assign clause_o       = clause_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign conflict_o     = conflict_q;
  assign conflict_idx_o = conf_idx_q;
  assign timeout_o      = timeout_q;
  assign all_c_sat_o    = all_sat_q;

endmodule

// File: tb/tb_clause_array_bcp.sv
// Bench for clause_array_bcp: default instance plus a MAX_ITER=1 instance sharing all inputs.
module tb_clause_array_bcp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [23:0] var_value_i;
  logic [7:0]  wr_i, rd_i;
  logic [15:0] clause_i;
  logic [3:0]  clause_len_i;
  logic        clear_i, start_i;

  logic [23:0] a_vv, b_vv;
  logic [15:0] a_cl, b_cl;
  logic [31:0] a_len, b_len;
  logic        a_busy, a_done, a_conf, a_tmo, a_sat;
  logic        b_busy, b_done, b_conf, b_tmo, b_sat;
  logic [2:0]  a_idx, b_idx;
`ifdef CLAUSE_ARRAY_BCP_STATS_EN
  logic [15:0] a_pc, b_pc;
`endif

  clause_array_bcp dut_a (
    .clk(clk), .rst(rst), .var_value_i(var_value_i), .var_value_o(a_vv),
    .wr_i(wr_i), .rd_i(rd_i), .clause_i(clause_i), .clause_o(a_cl),
    .clause_len_i(clause_len_i), .clause_len_o(a_len), .clear_i(clear_i),
    .start_i(start_i), .busy_o(a_busy), .done_o(a_done), .conflict_o(a_conf),
    .conflict_idx_o(a_idx), .timeout_o(a_tmo), .all_c_sat_o(a_sat)
`ifdef CLAUSE_ARRAY_BCP_STATS_EN
    , .pass_cnt_o(a_pc)
`endif
  );

  clause_array_bcp #(.MAX_ITER(1)) dut_b (
    .clk(clk), .rst(rst), .var_value_i(var_value_i), .var_value_o(b_vv),
    .wr_i(wr_i), .rd_i(rd_i), .clause_i(clause_i), .clause_o(b_cl),
    .clause_len_i(clause_len_i), .clause_len_o(b_len), .clear_i(clear_i),
    .start_i(start_i), .busy_o(b_busy), .done_o(b_done), .conflict_o(b_conf),
    .conflict_idx_o(b_idx), .timeout_o(b_tmo), .all_c_sat_o(b_sat)
`ifdef CLAUSE_ARRAY_BCP_STATS_EN
    , .pass_cnt_o(b_pc)
`endif
  );

  typedef struct {
    logic [23:0] w;
    logic        conf;
    logic [2:0]  idx;
    logic        tmo;
    logic        sat;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   d2_cyc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input int k, input logic [15:0] l, input logic [3:0] n);
    wr_i = 8'(1 << k);
    clause_i = l;
    clause_len_i = n;
    @(posedge clk); #1;
    wr_i = '0;
  endtask

  task automatic clr();
    clear_i = 1'b1;
    @(posedge clk); #1;
    clear_i = 1'b0;
  endtask

  task automatic rdback(input logic [7:0] sel, input logic [15:0] exp, input string tag);
    rd_i = sel;
    @(posedge clk); #1;
    rd_i = '0;
    chk(tag, a_cl, exp);
  endtask

  // Expected result is queued at start and popped when done_o appears.
  task automatic run(input logic [23:0] vin, input logic [23:0] w, input logic conf,
                     input logic [2:0] idx, input logic tmo, input logic sat,
                     input int cyc, input bit poke);
    exp_t e;
    int   n;
    bit   seen;
    e = '{w: w, conf: conf, idx: idx, tmo: tmo, sat: sat, cyc: cyc};
    sb.push_back(e);
    var_value_i = vin;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    chk("busy_after_start", a_busy, 1);
    n = 0; seen = 0; d2_cyc = 0;
    while (!seen && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (poke && n == 1) begin
        wr_i = 8'h80; clause_i = 16'hFFFF; clause_len_i = 4'hF; clear_i = 1'b1; start_i = 1'b1;
      end else begin
        wr_i = '0; clear_i = 1'b0; start_i = 1'b0;
      end
      if (b_done && d2_cyc == 0) d2_cyc = n;
      if (a_done) seen = 1;
    end
    if (!seen) chk("done_within_budget", 0, 1);
    e = sb.pop_front();
    chk("latency", n, e.cyc);
    chk("var_value", a_vv, e.w);
    chk("conflict", a_conf, e.conf);
    if (e.conf) chk("conflict_idx", a_idx, e.idx);
    chk("timeout", a_tmo, e.tmo);
    chk("all_c_sat", a_sat, e.sat);
    @(posedge clk);
    @(negedge clk);
    chk("done_one_cycle", a_done, 0);
    chk("busy_cleared", a_busy, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int ndone;
    rst = 1'b1; var_value_i = '0; wr_i = '0; rd_i = '0; clause_i = '0;
    clause_len_i = '0; clear_i = 1'b0; start_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_conflict", a_conf, 0);
    chk("rst_idx", a_idx, 0);
    chk("rst_timeout", a_tmo, 0);
    chk("rst_all_sat", a_sat, 1);
    chk("rst_var_value", a_vv, 0);
    chk("rst_clause_o", a_cl, 0);
    chk("rst_len", a_len, 0);

    wr(0, 16'h0005, 4'd2);
    rdback(8'h01, 16'h0005, "rd_slot0");
    chk("len_slot0", a_len[3:0], 4'd2);
    wr(1, 16'h0018, 4'd2);
    rdback(8'h03, 16'h001D, "rd_or_slots");
    rdback(8'h00, 16'h0000, "rd_none");
    chk("len_two_slots", a_len, 32'h0000_0022);

    clear_i = 1'b1; wr_i = 8'h04; clause_i = 16'h00FF; clause_len_i = 4'd3;
    @(posedge clk); #1;
    clear_i = 1'b0; wr_i = '0;
    chk("clear_priority_len", a_len, 0);
    rdback(8'h07, 16'h0000, "rd_after_clear");

    // Single implication; storage writes, clear and start are poked while busy.
    wr(0, 16'h0005, 4'd2);
    run(24'h000002, 24'h00002A, 0, 0, 0, 1, 2, 1);
    chk("busy_writes_ignored", a_len, 32'h0000_0002);
    // 11 counts as free; an incoming imp bit is preserved.
    run(24'h00001E, 24'h00002E, 0, 0, 0, 1, 2, 0);

    clr();
    wr(0, 16'h0006, 4'd2);
    wr(1, 16'h0018, 4'd2);
    run(24'h000001, 24'h000169, 0, 0, 0, 1, 3, 0);
    chk("mi1_latency", d2_cyc, 1);
    chk("mi1_var_value", b_vv, 24'h000029);
    chk("mi1_timeout", b_tmo, 1);
    chk("mi1_conflict", b_conf, 0);
    chk("mi1_all_sat", b_sat, 0);

    clr();
    wr(0, 16'h0001, 4'd1);
    wr(1, 16'h0002, 4'd1);
    run(24'h000000, 24'h000000, 1, 0, 0, 0, 1, 0);

    clr();
    wr(0, 16'h0010, 4'd1);
    wr(1, 16'h0020, 4'd1);
    wr(2, 16'h0001, 4'd1);
    wr(3, 16'h0004, 4'd1);
    run(24'h000012, 24'h000012, 1, 2, 0, 0, 1, 0);

    clr();
    wr(0, 16'h0001, 4'd1);
    wr(1, 16'h0004, 4'd1);
    wr(2, 16'h0010, 4'd1);
    wr(3, 16'h0020, 4'd1);
    run(24'h000001, 24'h000001, 1, 2, 0, 0, 1, 0);

    // Reset in the middle of the chain run.
    clr();
    wr(0, 16'h0006, 4'd2);
    wr(1, 16'h0018, 4'd2);
    var_value_i = 24'h000001;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(posedge clk); #1;
    chk("midrun_busy", a_busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", a_busy, 0);
    chk("abort_var_value", a_vv, 0);
    ndone = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (a_done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    @(posedge clk); #1;
    rdback(8'h01, 16'h0000, "rd_after_rst");
    run(24'h000000, 24'h000000, 0, 0, 0, 1, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
